// File: rtl/imm_decode_queue.sv
// Queued RV32I immediate decoder: decodes {inst, pc} at push and buffers results in a DEPTH-entry FIFO.
// Optional feature macro IMM_TARGET_EN adds a per-entry pc+imm branch/jump target.
module imm_decode_queue #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc,
  output logic [PC_W-1:0] out_target,
  output logic [31:0]     dec_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  logic [31:0]      dec_imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_ill;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  logic [XLEN-1:0]  mem_imm [DEPTH];
  logic [2:0]       mem_fmt [DEPTH];
  logic             mem_ill [DEPTH];
  logic [PC_W-1:0]  mem_pc  [DEPTH];

  // Every field is first sign-extended to 32 bits, then widened to XLEN.
  always_comb begin
    dec_imm32 = '0;
    dec_fmt   = FMT_NONE;
    dec_ill   = 1'b0;
    case (in_inst[6:0])
      OP_ARITH_IMM, OP_LOAD, OP_JALR: begin
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_fmt   = FMT_I;
      end
      OP_STORE: begin
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        dec_fmt   = FMT_S;
      end
      OP_BRANCH: begin
        dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
        dec_fmt   = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm32 = {in_inst[31:12], 12'b0};
        dec_fmt   = FMT_U;
      end
      OP_JAL: begin
        dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
        dec_fmt   = FMT_J;
      end
      OP_ARITH: ;
      default: dec_ill = 1'b1;
    endcase
    dec_imm = {{(XLEN-31){dec_imm32[31]}}, dec_imm32[30:0]};
  end

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dec_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        dec_count <= dec_count + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: outputs are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_imm[wr_ptr] <= dec_imm;
      mem_fmt[wr_ptr] <= dec_fmt;
      mem_ill[wr_ptr] <= dec_ill;
      mem_pc[wr_ptr]  <= in_pc;
    end
  end

  assign out_imm     = out_valid ? mem_imm[rd_ptr] : '0;
  assign out_fmt     = out_valid ? mem_fmt[rd_ptr] : '0;
  assign out_illegal = out_valid ? mem_ill[rd_ptr] : 1'b0;
  assign out_pc      = out_valid ? mem_pc[rd_ptr]  : '0;

`ifdef IMM_TARGET_EN
  logic [PC_W-1:0] dec_tgt;
  logic [PC_W-1:0] mem_tgt [DEPTH];

  always_comb begin
    dec_tgt = '0;
    if (dec_fmt == FMT_B || dec_fmt == FMT_J || in_inst[6:0] == OP_AUIPC)
      dec_tgt = in_pc + dec_imm[PC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (push) mem_tgt[wr_ptr] <= dec_tgt;
  end

  assign out_target = out_valid ? mem_tgt[rd_ptr] : '0;
`else
  assign out_target = '0;
`endif

endmodule

// File: tb/tb_imm_decode_queue.sv
// Bench for imm_decode_queue: directed vector table, hand-written FIFO corner cases,
// and randomized traffic checked against a queue-based reference model.
module tb_imm_decode_queue;
  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, out_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            in_ready, out_valid, out_illegal;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [PC_W-1:0] out_pc, out_target;
  logic [31:0]     dec_count;

  int checks = 0;
  int errors = 0;

  imm_decode_queue #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_pc(out_pc), .out_target(out_target),
    .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
    logic [PC_W-1:0] tgt;   // expected when the target feature is built in
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] tgt;
  } ent_t;

  vec_t vecs[11];
  ent_t model_q[$];
  logic [31:0] model_dec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [PC_W-1:0] exp_tgt(input logic [PC_W-1:0] t);
`ifdef IMM_TARGET_EN
    return t;
`else
    return '0 & t;
`endif
  endfunction

  // Reference decode: immediates rebuilt arithmetically from the ISA field layout.
  function automatic ent_t ref_decode(input logic [31:0] inst, input logic [PC_W-1:0] pc);
    ent_t e;
    int s;
    longint v;
    logic [6:0] op;
    s = $signed(inst);
    op = inst[6:0];
    v = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin
      v = s >>> 20; e.fmt = 3'd1;
    end else if (op == 7'h23) begin
      v = (s >>> 25) * 32 + int'(inst[11:7]); e.fmt = 3'd2;
    end else if (op == 7'h63) begin
      v = (s >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32
          + int'(inst[11:8]) * 2;
      e.fmt = 3'd3;
    end else if (op == 7'h37 || op == 7'h17) begin
      v = (s >>> 12) * 4096; e.fmt = 3'd4;
    end else if (op == 7'h6F) begin
      v = (s >>> 31) * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048
          + int'(inst[30:21]) * 2;
      e.fmt = 3'd5;
    end else if (op != 7'h33) begin
      e.ill = 1'b1;
    end
    e.imm = XLEN'(v);
    e.pc  = pc;
    if (e.fmt == 3'd3 || e.fmt == 3'd5 || op == 7'h17) e.tgt = exp_tgt(pc + PC_W'(v));
    else e.tgt = '0;
    return e;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".out_imm"}, 64'(out_imm), 64'd0);
    check({tag, ".out_fmt"}, 64'(out_fmt), 64'd0);
    check({tag, ".out_illegal"}, 64'(out_illegal), 64'd0);
    check({tag, ".out_pc"}, 64'(out_pc), 64'd0);
    check({tag, ".out_target"}, 64'(out_target), 64'd0);
  endtask

  logic [31:0] rnd_inst;
  logic [6:0]  ops[9];
  logic        mdl_push, mdl_pop;

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'h100,  32'hFFFFFFFF, 3'd1, 1'b0, 32'h0};
    vecs[1]  = '{32'hFE112E23, 32'h104,  32'hFFFFFFFC, 3'd2, 1'b0, 32'h0};
    vecs[2]  = '{32'h123452B7, 32'h108,  32'h12345000, 3'd4, 1'b0, 32'h0};
    vecs[3]  = '{32'hFE000CE3, 32'h200,  32'hFFFFFFF8, 3'd3, 1'b0, 32'h1F8};
    vecs[4]  = '{32'h0000007F, 32'h10C,  32'h0,        3'd0, 1'b1, 32'h0};
    vecs[5]  = '{32'h002081B3, 32'h110,  32'h0,        3'd0, 1'b0, 32'h0};
    vecs[6]  = '{32'h00001297, 32'h1000, 32'h1000,     3'd4, 1'b0, 32'h2000};
    vecs[7]  = '{32'h0080006F, 32'h300,  32'h8,        3'd5, 1'b0, 32'h308};
    vecs[8]  = '{32'hFF00A283, 32'h114,  32'hFFFFFFF0, 3'd1, 1'b0, 32'h0};
    vecs[9]  = '{32'h000080E7, 32'h118,  32'h0,        3'd1, 1'b0, 32'h0};
    vecs[10] = '{32'hFFDFF06F, 32'h400,  32'hFFFFFFFC, 3'd5, 1'b0, 32'h3FC};
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    @(negedge clk);
    step();
    reset = 1'b0;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.dec_count", 64'(dec_count), 64'd0);
    check_idle("reset");

    // Directed vectors: push one, inspect head, pop it.
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = vecs[i].pc;
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d.out_imm", i), 64'(out_imm), 64'(vecs[i].imm));
      check($sformatf("vec%0d.out_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
      check($sformatf("vec%0d.out_illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
      check($sformatf("vec%0d.out_pc", i), 64'(out_pc), 64'(vecs[i].pc));
      check($sformatf("vec%0d.out_target", i), 64'(out_target), 64'(exp_tgt(vecs[i].tgt)));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("vec%0d.popped", i), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d.dec_count", i), 64'(dec_count), 64'(i + 1));
    end

    // Fill to DEPTH with the consumer stalled; the third push must be held off.
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'hA00;
    step();
    check("full.ready_after1", 64'(in_ready), 64'd1);
    in_inst = 32'h00200093; in_pc = 32'hA04;
    step();
    check("full.ready_after2", 64'(in_ready), 64'd0);
    in_inst = 32'h00300093; in_pc = 32'hA08;
    step();
    check("full.still_full", 64'(in_ready), 64'd0);
    check("full.head_stable_pc", 64'(out_pc), 64'hA00);
    check("full.head_stable_imm", 64'(out_imm), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("full.pop_head_pc", 64'(out_pc), 64'hA04);
    check("full.pop_dec", 64'(dec_count), 64'd12);
    in_valid = 1'b1; in_inst = 32'h00400093; in_pc = 32'hA0C;
    step();
    check("pushpop.valid", 64'(out_valid), 64'd1);
    check("pushpop.head_pc", 64'(out_pc), 64'hA0C);
    check("pushpop.head_imm", 64'(out_imm), 64'd4);
    check("pushpop.in_ready", 64'(in_ready), 64'd1);
    check("pushpop.dec", 64'(dec_count), 64'd13);
    in_valid = 1'b0;
    step();
    check("pushpop.drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Flush with a concurrent push and pop: flush wins.
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'hB00;
    step();
    in_pc = 32'hB04;
    step();
    flush = 1'b1; in_pc = 32'hB08; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush.dec_count", 64'(dec_count), 64'd0);
    check("flush.in_ready", 64'(in_ready), 64'd1);
    check_idle("flush");
    step();
    check("flush.none_stored", 64'(out_valid), 64'd0);

    // Randomized traffic against the queue model.
    model_q.delete();
    model_dec = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 2);
      rnd_inst  = $urandom;
      if ($urandom_range(0, 9) < 8) rnd_inst[6:0] = ops[$urandom_range(0, 8)];
      in_inst = rnd_inst;
      in_pc   = $urandom;
      check("rnd.in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
      check("rnd.out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      check("rnd.dec_count", 64'(dec_count), 64'(model_dec));
      if (model_q.size() != 0) begin
        check("rnd.out_imm", 64'(out_imm), 64'(model_q[0].imm));
        check("rnd.out_fmt", 64'(out_fmt), 64'(model_q[0].fmt));
        check("rnd.out_illegal", 64'(out_illegal), 64'(model_q[0].ill));
        check("rnd.out_pc", 64'(out_pc), 64'(model_q[0].pc));
        check("rnd.out_target", 64'(out_target), 64'(model_q[0].tgt));
      end else begin
        check("rnd.idle_imm", 64'(out_imm), 64'd0);
        check("rnd.idle_pc", 64'(out_pc), 64'd0);
      end
      mdl_push = in_valid && (model_q.size() < DEPTH);
      mdl_pop  = out_ready && (model_q.size() != 0);
      step();
      if (flush) begin
        model_q.delete();
        model_dec = 0;
      end else begin
        if (mdl_pop) begin
          void'(model_q.pop_front());
          model_dec++;
        end
        if (mdl_push) model_q.push_back(ref_decode(rnd_inst, in_pc));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
